pair_triple_arbiter: RTL and testbench
======================================

Name: pair_triple_arbiter

Overview:
- Shares one 3-input pair/triple (majority) detector among NREQ requesters.
- Each requester offers a 3-bit sample over a val/rdy handshake.
- A round-robin arbiter grants at most one requester per cycle and evaluates that requester's sample.
- The result is held in a single-entry output register with its own val/rdy handshake, and a saturating counter tallies positive detections.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must equal clog2(NREQ).
- CNT_W, 8, width of the saturating hit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_val  input  NREQ  bit i: requester i has a valid sample.
- req_bits  input  3*NREQ  requester i sample occupies bits [3i+2:3i].
- req_rdy  output  NREQ  bit i: requester i's sample is accepted this cycle.
- resp_val  output  1  output register holds a valid result.
- resp_rdy  input  1  consumer accepts the result this cycle.
- resp_id  output  ID_W  index of the requester that produced the result.
- resp_bits  output  3  sample that was evaluated.
- resp_out  output  1  1 when at least two of resp_bits are 1.
- hit_count  output  CNT_W  number of accepted samples with result 1, saturating.

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk):
  - resp_val=0, resp_id=0, resp_bits=0, resp_out=0, hit_count=0.
  - Round-robin pointer ptr=0.
  - req_rdy is all zero while reset is asserted.
- A reset that lands mid-operation discards any held result with no response. No partial state survives.
- Detection function: out = (b0&b1) | (b0&b2) | (b1&b2). It is combinational on the granted sample.
- Output register state machine:
  - EMPTY (resp_val=0): can_accept=1.
  - FULL (resp_val=1): can_accept = resp_rdy. This is the drain-and-refill case.
- Arbitration:
  - Scan req_val starting at index ptr, ascending with wrap-around modulo NREQ.
  - The first set bit is the grant g.
  - If no bit is set, there is no grant.
- Handshake:
  - req_rdy[i] = can_accept & (grant==i). It is one-hot or zero.
  - req_rdy is combinational from req_val, ptr, resp_val and resp_rdy.
  - A transfer occurs when req_val[g] & req_rdy[g].
- On a transfer at the clock edge:
  - resp_val<=1, resp_id<=g, resp_bits<=sample g, resp_out<=out.
  - ptr<=(g+1) mod NREQ.
- Drain without transfer: resp_val&resp_rdy with no new transfer sets resp_val<=0. The resp_id, resp_bits and resp_out contents are don't-care after that.
- Simultaneous drain and transfer: the new result replaces the old one in the same edge and resp_val stays 1. Throughput is 1 result per cycle.
- Backpressure: while FULL and resp_rdy=0, all req_rdy=0 and every output register holds stable.
- ptr changes only on a transfer. An idle cycle or a stalled cycle leaves ptr unchanged.
- Latency: a sample accepted at edge N is visible on the resp_* outputs after edge N.
- hit_count:
  - Increments by 1 on each transfer whose out=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - It is unaffected by resp_rdy.
- Requesters must hold req_val and their bits stable until accepted. The arbiter does not require this for correctness: it samples only in the accepting cycle.

Test Plan:
- Reset then single request: reset, then req_val=0001, bits0=3'b011 -> req_rdy=0001 for one cycle. Next cycle resp_val=1, resp_id=0, resp_out=1, hit_count=1.
- Majority table: requester 2 sends all 8 values 000..111 with resp_rdy=1 -> resp_out=1 only for 011,101,110,111. hit_count=4.
- Round-robin fairness: all req_val=1111 held, resp_rdy=1 -> grant order 0,1,2,3,0,1, one result per cycle, resp_val continuously 1.
- Backpressure: fill output, then resp_rdy=0 for 5 cycles with req_val=1111 -> req_rdy=0000, resp_* stable, ptr unchanged. On release, the next grant is the index after the held id.
- Saturation: CNT_W=2, send 5 samples of 111 -> hit_count goes 1,2,3,3,3.
- Async reset mid-stream: drop rst_n between clock edges while FULL -> resp_val=0, hit_count=0 immediately. After release, req_val=1000 yields grant 3, and ptr=0 afterward.

Source files
------------

// File: rtl/pair_triple_arbiter.sv
// Round-robin arbiter sharing one 3-input majority detector among NREQ requesters,
// with a single-entry val/rdy result register and a saturating hit counter.
module pair_triple_arbiter #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_val,
    input  logic [3*NREQ-1:0]    req_bits,
    output logic [NREQ-1:0]      req_rdy,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [ID_W-1:0]      resp_id,
    output logic [2:0]           resp_bits,
    output logic                 resp_out,
    output logic [CNT_W-1:0]     hit_count
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_resp_id;
    logic [2:0]         r_resp_bits;
    logic               r_resp_out;
    logic [CNT_W-1:0]   r_hit_count;

    logic               w_can_accept;
    logic               w_grant_vld;
    logic [ID_W-1:0]    w_grant;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [2:0]         w_sample;
    logic               w_maj;
    logic               w_xfer;

    function automatic logic f_majority(input logic [2:0] b);
        return (b[0] & b[1]) | (b[0] & b[2]) | (b[1] & b[2]);
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Scan from r_ptr upward with wrap-around; first requesting index wins.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (!w_grant_vld && req_val[idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = ID_W'(idx);
            end
        end
    end

    assign w_can_accept = (r_state == S_EMPTY) | resp_rdy;
    assign w_xfer       = rst_n & w_can_accept & w_grant_vld;
    assign w_sample     = req_bits[3*w_grant +: 3];
    assign w_maj        = f_majority(w_sample);
    assign w_ptr_nxt    = (w_grant == ID_W'(NREQ - 1)) ? '0 : w_grant + 1'b1;

    // Grant is only visible outside reset so nothing can appear accepted while rst_n is low.
    always_comb begin
        req_rdy = '0;
        if (w_xfer) begin
            req_rdy[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = S_FULL;
        end else if ((r_state == S_FULL) && resp_rdy) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_ptr       <= '0;
            r_resp_id   <= '0;
            r_resp_bits <= '0;
            r_resp_out  <= 1'b0;
            r_hit_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_resp_id   <= w_grant;
                r_resp_bits <= w_sample;
                r_resp_out  <= w_maj;
                r_ptr       <= w_ptr_nxt;
                if (w_maj) begin
                    r_hit_count <= f_sat_inc(r_hit_count);
                end
            end
        end
    end

    assign resp_val  = (r_state == S_FULL);
    assign resp_id   = r_resp_id;
    assign resp_bits = r_resp_bits;
    assign resp_out  = r_resp_out;
    assign hit_count = r_hit_count;

endmodule

// File: tb/tb_pair_triple_arbiter.sv
// Directed bench for pair_triple_arbiter: main instance (CNT_W=8) plus a
// narrow-counter instance (CNT_W=2) to exercise hit_count saturation.
module tb_pair_triple_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_val;
    logic [11:0] req_bits;
    logic [3:0]  req_rdy;
    logic        resp_val;
    logic        resp_rdy;
    logic [1:0]  resp_id;
    logic [2:0]  resp_bits;
    logic        resp_out;
    logic [7:0]  hit_count;

    logic [3:0]  s_req_val;
    logic [11:0] s_req_bits;
    logic [3:0]  s_req_rdy;
    logic        s_resp_val;
    logic        s_resp_rdy;
    logic [1:0]  s_resp_id;
    logic [2:0]  s_resp_bits;
    logic        s_resp_out;
    logic [1:0]  s_hit_count;

    int errors = 0;
    int checks = 0;

    pair_triple_arbiter #(.NREQ(4), .ID_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_bits(req_bits),
        .req_rdy(req_rdy), .resp_val(resp_val), .resp_rdy(resp_rdy),
        .resp_id(resp_id), .resp_bits(resp_bits), .resp_out(resp_out),
        .hit_count(hit_count)
    );

    pair_triple_arbiter #(.NREQ(4), .ID_W(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_val(s_req_val), .req_bits(s_req_bits),
        .req_rdy(s_req_rdy), .resp_val(s_resp_val), .resp_rdy(s_resp_rdy),
        .resp_id(s_resp_id), .resp_bits(s_resp_bits), .resp_out(s_resp_out),
        .hit_count(s_hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0]  maj_tbl = 4'b0000;
    logic [7:0]  maj_exp = 8'b1110_1000;
    logic [1:0]  rr_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [2:0]  rr_bits [4] = '{3'b000, 3'b001, 3'b110, 3'b111};
    logic        rr_out [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst_n      = 1'b0;
        req_val    = 4'b1111;
        req_bits   = '0;
        resp_rdy   = 1'b0;
        s_req_val  = '0;
        s_req_bits = '0;
        s_resp_rdy = 1'b0;
        #2;
        check("rst_resp_val", 32'(resp_val), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_bits", 32'(resp_bits), 32'd0);
        check("rst_resp_out", 32'(resp_out), 32'd0);
        check("rst_hit", 32'(hit_count), 32'd0);
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        req_val = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 0
        req_val  = 4'b0001;
        req_bits = 12'b000_000_000_011;
        #1;
        check("single_rdy", 32'(req_rdy), 32'b0001);
        step();
        req_val = '0;
        check("single_val", 32'(resp_val), 32'd1);
        check("single_id", 32'(resp_id), 32'd0);
        check("single_out", 32'(resp_out), 32'd1);
        check("single_bits", 32'(resp_bits), 32'b011);
        check("single_hit", 32'(hit_count), 32'd1);
        #1;
        check("single_rdy_drop", 32'(req_rdy), 32'd0);

        // Majority truth table via requester 2
        do_reset();
        resp_rdy = 1'b1;
        for (int v = 0; v < 8; v++) begin
            req_val  = 4'b0100;
            req_bits = 12'(v) << 6;
            #1;
            check("maj_rdy", 32'(req_rdy), 32'b0100);
            step();
            check("maj_val", 32'(resp_val), 32'd1);
            check("maj_id", 32'(resp_id), 32'd2);
            check("maj_bits", 32'(resp_bits), 32'(v));
            check("maj_out", 32'(resp_out), 32'(maj_exp[v]));
        end
        check("maj_hit", 32'(hit_count), 32'd4);
        req_val = '0;
        step();
        check("drain_val", 32'(resp_val), 32'd0);
        check("idle_hit", 32'(hit_count), 32'd4);

        // Round-robin with all requesting
        do_reset();
        resp_rdy = 1'b1;
        req_val  = 4'b1111;
        req_bits = {rr_bits[3], rr_bits[2], rr_bits[1], rr_bits[0]};
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_rdy", 32'(req_rdy), 32'(4'b0001 << rr_exp[k]));
            step();
            check("rr_val", 32'(resp_val), 32'd1);
            check("rr_id", 32'(resp_id), 32'(rr_exp[k]));
            check("rr_bits", 32'(resp_bits), 32'(rr_bits[rr_exp[k]]));
            check("rr_out", 32'(resp_out), 32'(rr_out[rr_exp[k]]));
        end
        check("rr_hit", 32'(hit_count), 32'd2);

        // Backpressure while holding id 1
        resp_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_rdy", 32'(req_rdy), 32'd0);
            check("bp_val", 32'(resp_val), 32'd1);
            check("bp_id", 32'(resp_id), 32'd1);
            check("bp_bits", 32'(resp_bits), 32'b001);
            check("bp_hit", 32'(hit_count), 32'd2);
            step();
        end
        resp_rdy = 1'b1;
        #1;
        check("bp_release_rdy", 32'(req_rdy), 32'b0100);
        step();
        check("bp_release_id", 32'(resp_id), 32'd2);
        check("bp_release_hit", 32'(hit_count), 32'd3);

        // Asynchronous reset mid-cycle while FULL
        resp_rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_val", 32'(resp_val), 32'd0);
        check("arst_hit", 32'(hit_count), 32'd0);
        check("arst_rdy", 32'(req_rdy), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        resp_rdy = 1'b1;
        req_val  = 4'b1000;
        #1;
        check("arst_grant3_rdy", 32'(req_rdy), 32'b1000);
        step();
        check("arst_grant3_id", 32'(resp_id), 32'd3);
        check("arst_grant3_val", 32'(resp_val), 32'd1);
        req_val = 4'b1111;
        #1;
        check("arst_ptr0", 32'(req_rdy), 32'b0001);
        step();
        req_val = '0;

        // Saturating counter on the narrow instance
        s_resp_rdy = 1'b1;
        s_req_val  = 4'b0001;
        s_req_bits = 12'b000_000_000_111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("sat_hit", 32'(s_hit_count), 32'(sat_exp[k]));
        end
        check("sat_val", 32'(s_resp_val), 32'd1);
        s_req_val = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
